// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad word buffer.
package keypad_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        DONE    = 2'd2
    } word_buf_state_t;

    localparam logic [7:0] ASCII_A = 8'd65;
    localparam logic [7:0] ASCII_Z = 8'd90;

    // True for an upper-case ASCII letter.
    function automatic logic is_upper_letter(input logic [7:0] c);
        return (c >= ASCII_A) && (c <= ASCII_Z);
    endfunction

endpackage

// File: rtl/keypad_word_buffer_rise_detect.sv
// Rising-edge detector for a level input. The history register resets to
// RST_VAL so a level already high at reset release produces no event.
module rise_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    // Remember the previous level of d.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= RST_VAL;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/keypad_word_buffer.sv
// Collects keypad letters into a fixed-length word and hands the finished
// word to game logic.
//
// word_valid/word_ready: once word_valid rises, word_data is held stable and
// word_valid stays high until a cycle in which word_ready is high; that cycle
// is the transfer, and the buffer is empty and word_valid low on the next one.
module keypad_word_buffer
    import keypad_pkg::*;
#(
    parameter  int WORD_LEN = 5,
    localparam int CNT_W    = $clog2(WORD_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  letter_ready,
    input  logic [7:0]            letter_data,
    input  logic                  submit_word,
    input  logic                  game_end,
    input  logic                  word_ready,
    output logic                  word_valid,
    output logic [8*WORD_LEN-1:0] word_data,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  reject,
    output logic                  game_over,
    output logic [1:0]            state_dbg
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORD_LEN);

    logic ev_letter;
    logic ev_submit;
    logic ev_game_end;

    word_buf_state_t       state_q, state_n;
    logic [CNT_W-1:0]      count_q, count_n;
    logic [8*WORD_LEN-1:0] word_q, word_n;
    logic                  reject_q, reject_n;

    rise_detect #(.RST_VAL(1'b1)) u_rise_letter (
        .clk  (clk),
        .rst  (rst),
        .d    (letter_ready),
        .rise (ev_letter)
    );

    rise_detect #(.RST_VAL(1'b1)) u_rise_submit (
        .clk  (clk),
        .rst  (rst),
        .d    (submit_word),
        .rise (ev_submit)
    );

    rise_detect #(.RST_VAL(1'b1)) u_rise_game_end (
        .clk  (clk),
        .rst  (rst),
        .d    (game_end),
        .rise (ev_game_end)
    );

    // Register FSM state, word buffer, letter count and the reject pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= COLLECT;
            count_q  <= '0;
            word_q   <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            count_q  <= count_n;
            word_q   <= word_n;
            reject_q <= reject_n;
        end
    end

    // Next state: game end first, then handshake, then submit, then letter.
    always_comb begin
        state_n  = state_q;
        count_n  = count_q;
        word_n   = word_q;
        reject_n = 1'b0;

        case (state_q)
            COLLECT: begin
                if (ev_game_end) begin
                    state_n = DONE;
                    count_n = '0;
                    word_n  = '0;
                end else if (ev_submit) begin
                    // A letter in the same cycle is never stored.
                    if (count_q == FULL_CNT) begin
                        state_n = HOLD;
                    end else begin
                        reject_n = 1'b1;
                    end
                    if (ev_letter) begin
                        reject_n = 1'b1;
                    end
                end else if (ev_letter) begin
                    if (is_upper_letter(letter_data) && (count_q < FULL_CNT)) begin
                        for (int i = 0; i < WORD_LEN; i++) begin
                            if (count_q == CNT_W'(i)) begin
                                word_n[8*(WORD_LEN-1-i) +: 8] = letter_data;
                            end
                        end
                        count_n = count_q + 1'b1;
                    end else begin
                        reject_n = 1'b1;
                    end
                end
            end

            HOLD: begin
                if (ev_game_end) begin
                    state_n = DONE;
                    count_n = '0;
                    word_n  = '0;
                end else begin
                    if (word_ready) begin
                        state_n = COLLECT;
                        count_n = '0;
                        word_n  = '0;
                    end
                    // The word is owned by game logic; keypad input is refused.
                    if (ev_letter || ev_submit) begin
                        reject_n = 1'b1;
                    end
                end
            end

            DONE: begin
                // Terminal until reset; events are silently ignored.
                count_n = '0;
                word_n  = '0;
            end

            default: begin
                state_n = COLLECT;
                count_n = '0;
                word_n  = '0;
            end
        endcase
    end

    assign word_valid = (state_q == HOLD);
    assign game_over  = (state_q == DONE);
    assign word_data  = word_q;
    assign count      = count_q;
    assign full       = (count_q == FULL_CNT);
    assign reject     = reject_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_keypad_word_buffer.sv
// Self-checking bench for keypad_word_buffer with a queue-based word model.
module tb_keypad_word_buffer;

    localparam int WL = 5;
    localparam int DW = 8 * WL;

    logic          tb_clk;
    logic          rst;
    logic          letter_ready;
    logic [7:0]    letter_data;
    logic          submit_word;
    logic          game_end;
    logic          word_ready;
    logic          word_valid;
    logic [DW-1:0] word_data;
    logic [2:0]    count;
    logic          full;
    logic          reject;
    logic          game_over;
    logic [1:0]    state_dbg;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    keypad_word_buffer #(.WORD_LEN(WL)) dut (
        .clk          (tb_clk),
        .rst          (rst),
        .letter_ready (letter_ready),
        .letter_data  (letter_data),
        .submit_word  (submit_word),
        .game_end     (game_end),
        .word_ready   (word_ready),
        .word_valid   (word_valid),
        .word_data    (word_data),
        .count        (count),
        .full         (full),
        .reject       (reject),
        .game_over    (game_over),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    always @(posedge tb_clk) cycle++;

    // ---------------- behavioural model ----------------
    logic [7:0] exp_q[$];     // stored letters, slot 0 first
    logic       m_holding;    // a complete word is offered
    logic       m_over;       // game finished
    logic       m_reject;
    logic       m_on = 1'b0;
    logic       p_letter, p_submit, p_end;

    function automatic logic [DW-1:0] model_word();
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < exp_q.size(); i++) w[DW-1-8*i -: 8] = exp_q[i];
        return w;
    endfunction

    // Advance the model on every rising edge using the sampled inputs.
    always @(posedge tb_clk) begin
        logic evl, evs, evg;
        if (rst) begin
            exp_q.delete();
            m_holding = 1'b0;
            m_over    = 1'b0;
            m_reject  = 1'b0;
            p_letter  = 1'b1;
            p_submit  = 1'b1;
            p_end     = 1'b1;
            m_on      = 1'b1;
        end else if (m_on) begin
            evl = letter_ready && !p_letter;
            evs = submit_word && !p_submit;
            evg = game_end && !p_end;
            p_letter = letter_ready;
            p_submit = submit_word;
            p_end    = game_end;
            m_reject = 1'b0;
            if (m_over) begin
                // nothing changes after the game ends
            end else if (evg) begin
                m_over = 1'b1;
                m_holding = 1'b0;
                exp_q.delete();
            end else if (m_holding) begin
                if (word_ready) begin
                    m_holding = 1'b0;
                    exp_q.delete();
                end
                if (evl || evs) m_reject = 1'b1;
            end else if (evs) begin
                if (exp_q.size() == WL) m_holding = 1'b1;
                else m_reject = 1'b1;
                if (evl) m_reject = 1'b1;
            end else if (evl) begin
                if (letter_data >= 8'd65 && letter_data <= 8'd90 && exp_q.size() < WL)
                    exp_q.push_back(letter_data);
                else
                    m_reject = 1'b1;
            end
        end
    end

    // ---------------- scoreboard compare, every cycle ----------------
    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cycle, act, exp);
        end
    endtask

    always @(negedge tb_clk) begin
        if (m_on) begin
            cmp("word_data",  64'(word_data),  64'(model_word()));
            cmp("count",      64'(count),      64'(exp_q.size()));
            cmp("full",       64'(full),       64'(exp_q.size() == WL));
            cmp("word_valid", 64'(word_valid), 64'(m_holding));
            cmp("reject",     64'(reject),     64'(m_reject));
            cmp("game_over",  64'(game_over),  64'(m_over));
        end
    end

    // ---------------- driver tasks (inputs change on negedge) ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge tb_clk);
    endtask

    task automatic do_reset();
        @(negedge tb_clk); rst = 1'b1;
        @(negedge tb_clk); rst = 1'b0;
    endtask

    task automatic send_letter(input logic [7:0] c);
        @(negedge tb_clk); letter_ready = 1'b1; letter_data = c;
        @(negedge tb_clk); letter_ready = 1'b0;
    endtask

    task automatic send_submit();
        @(negedge tb_clk); submit_word = 1'b1;
        @(negedge tb_clk); submit_word = 1'b0;
    endtask

    task automatic send_word(input string s);
        for (int i = 0; i < s.len(); i++) send_letter(s[i]);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        rst = 1'b1; letter_ready = 1'b1; letter_data = 8'h41;
        submit_word = 1'b1; game_end = 1'b0; word_ready = 1'b0;

        // 1: inputs held high through reset give no event after release
        idle(3);
        rst = 1'b0;
        idle(2);
        letter_ready = 1'b0; submit_word = 1'b0;
        idle(1);
        cmp("lit_reset_count",  64'(count),  64'd0);
        cmp("lit_reset_reject", 64'(reject), 64'd0);

        // 2: HELLO, submit, hold 10 cycles, then accept
        send_word("HELLO");
        send_submit();
        for (int i = 0; i < 10; i++) begin
            cmp("lit_hold_data",  64'(word_data),  64'h48454C4C4F);
            cmp("lit_hold_valid", 64'(word_valid), 64'd1);
            idle(1);
        end
        cmp("lit_model_hello", 64'(model_word()), 64'h48454C4C4F);
        cmp("lit_hold_full", 64'(full), 64'd1);
        word_ready = 1'b1;
        idle(1);
        word_ready = 1'b0;
        cmp("lit_accept_count", 64'(count),     64'd0);
        cmp("lit_accept_data",  64'(word_data), 64'd0);

        // 3: short submit is refused, letters kept
        send_word("AB");
        send_submit();
        cmp("lit_short_reject", 64'(reject),     64'd1);
        cmp("lit_short_valid",  64'(word_valid), 64'd0);
        cmp("lit_short_data",   64'(word_data),  64'h4142000000);
        idle(1);
        cmp("lit_short_pulse",  64'(reject),     64'd0);
        do_reset();

        // 4: overflow and non-letter
        send_word("ABCDEF");
        cmp("lit_over_reject", 64'(reject),    64'd1);
        cmp("lit_over_data",   64'(word_data), 64'h4142434445);
        send_letter(8'h31);
        cmp("lit_digit_reject", 64'(reject), 64'd1);
        cmp("lit_digit_count",  64'(count),  64'd5);
        do_reset();

        // 5: game end while holding
        send_word("HELLO");
        send_submit();
        @(negedge tb_clk); game_end = 1'b1;
        @(negedge tb_clk);
        cmp("lit_end_valid", 64'(word_valid), 64'd0);
        cmp("lit_end_over",  64'(game_over),  64'd1);
        cmp("lit_end_count", 64'(count),      64'd0);
        game_end = 1'b0;
        send_letter("Z");
        send_submit();
        cmp("lit_end_noreject", 64'(reject), 64'd0);
        do_reset();

        // 6: same-cycle submit + letter at count 4, then reset mid-HOLD
        send_word("ABCD");
        @(negedge tb_clk); submit_word = 1'b1; letter_ready = 1'b1; letter_data = "E";
        @(negedge tb_clk); submit_word = 1'b0; letter_ready = 1'b0;
        cmp("lit_same_reject", 64'(reject),     64'd1);
        cmp("lit_same_count",  64'(count),      64'd4);
        cmp("lit_same_valid",  64'(word_valid), 64'd0);
        send_letter("E");
        send_submit();
        cmp("lit_hold2_valid", 64'(word_valid), 64'd1);
        do_reset();
        cmp("lit_rst_valid", 64'(word_valid), 64'd0);
        cmp("lit_rst_count", 64'(count),      64'd0);
        cmp("lit_rst_data",  64'(word_data),  64'd0);

        // Random phase: mostly letters, occasional junk, submits, accepts, ends.
        for (int n = 0; n < 3000; n++) begin
            @(negedge tb_clk);
            rst          = ($urandom_range(0, 199) == 0);
            game_end     = ($urandom_range(0, 149) == 0);
            letter_ready = $urandom_range(0, 1);
            letter_data  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                       : 8'($urandom_range(65, 90));
            submit_word  = ($urandom_range(0, 5) == 0);
            word_ready   = ($urandom_range(0, 3) == 0);
        end
        @(negedge tb_clk);
        rst = 1'b0; game_end = 1'b0; letter_ready = 1'b0;
        submit_word = 1'b0; word_ready = 1'b0;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
